pulse_width_meter: RTL and testbench

//  Receive-side companion to the one-shot (monostable) pulse generators: samples an

---
 rtl/pulse_meas_pkg.sv | 19 +
 rtl/pulse_sync.sv | 56 +++++
 rtl/pulse_width_meter.sv | 111 +++++++++++
 tb/tb_pulse_width_meter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_pkg.sv
// Shared state encoding, default widths and saturation helper for the pulse width meter.
package pulse_meas_pkg;

   typedef enum logic [1:0] {
      ST_ARM  = 2'd0,
      ST_WAIT = 2'd1,
      ST_MEAS = 2'd2
   } meas_state_e;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_LEN    = 3;

   // All-ones value of a w-bit counter, for w in 1..63.
   function automatic logic [63:0] sat_of(input int w);
      return {64{1'b1}} >> (64 - w);
   endfunction

endpackage

// File: rtl/pulse_sync.sv
// Input synchronizer chain with an optional run-length glitch filter.
// Macro GLITCH_FILTER_EN enables the filter stage.
module pulse_sync
   import pulse_meas_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LEN    = DEF_FILT_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse_in,
   output logic lvl_raw
);

   if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_param_check
      $error("pulse_sync: SYNC_STAGES and FILT_LEN must both be >= 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
   end

`ifdef GLITCH_FILTER_EN
   logic [FILT_LEN-1:0] hist_d;
   logic [FILT_LEN-2:0] hist_q;
   logic                lvl_d;
   logic                lvl_q;

   // The level only follows the input once FILT_LEN consecutive samples agree.
   assign hist_d = {hist_q, sync_q[SYNC_STAGES-1]};

   always_comb begin
      lvl_d = lvl_q;
      if (&hist_d)       lvl_d = 1'b1;
      else if (~|hist_d) lvl_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         lvl_q  <= 1'b0;
      end else begin
         hist_q <= hist_d[FILT_LEN-2:0];
         lvl_q  <= lvl_d;
      end
   end

   assign lvl_raw = lvl_d;
`else
   assign lvl_raw = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pulse_width_meter.sv
// Measures active pulse widths on an async line and offers them on a valid/ready port.
// Macro GLITCH_FILTER_EN enables the input glitch filter inside pulse_sync.
//
// state   | meaning
// ST_ARM  | idle or disabled; waiting to see the inactive level
// ST_WAIT | armed; waiting for the leading edge
// ST_MEAS | pulse in progress; counting active cycles
module pulse_width_meter
   import pulse_meas_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LEN    = DEF_FILT_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pol,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] width_out,
   output logic             width_ovf,
   output logic             width_valid,
   input  logic             width_ready,
   output logic             busy,
   output logic             dropped
);

   localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_of(CNT_W));

   meas_state_e      state_q;
   logic             pol_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] width_q;
   logic             ovf_q;
   logic             valid_q;
   logic             dropped_q;
   logic             lvl_raw;
   logic             lvl;

   pulse_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .lvl_raw  (lvl_raw)
   );

   // While arming the live pol input is used; afterwards the latched copy.
   assign lvl   = ~(lvl_raw ^ ((state_q == ST_ARM) ? pol : pol_q));
   assign cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ARM;
         pol_q     <= 1'b0;
         cnt_q     <= '0;
         width_q   <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         dropped_q <= 1'b0;
         if (valid_q && width_ready) valid_q <= 1'b0;
         if (!en) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_ARM: begin
                  if (!lvl) begin
                     state_q <= ST_WAIT;
                     pol_q   <= pol;
                  end
               end
               ST_WAIT: begin
                  if (lvl) begin
                     state_q <= ST_MEAS;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               ST_MEAS: begin
                  if (lvl) begin
                     cnt_q <= cnt_d;
                  end else begin
                     state_q <= ST_WAIT;
                     // A pending, unaccepted result wins over the new one.
                     if (!valid_q || width_ready) begin
                        width_q <= cnt_q;
                        ovf_q   <= (cnt_q == SAT);
                        valid_q <= 1'b1;
                     end else begin
                        dropped_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= ST_ARM;
            endcase
         end
      end
   end

   assign width_out   = width_q;
   assign width_ovf   = ovf_q;
   assign width_valid = valid_q;
   assign busy        = (state_q == ST_MEAS);
   assign dropped     = dropped_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter: directed table, corner sequences, random pulses.
module tb_pulse_width_meter;

   logic        clk = 1'b0;
   logic        rst, en, pol, pulse_in, width_ready;
   logic [15:0] width_out;
   logic        width_ovf, width_valid, busy, dropped;
   logic [3:0]  w4_out;
   logic        w4_ovf, w4_valid, w4_busy, w4_dropped;

   int n_tests = 0;
   int n_fail  = 0;
   int res_w[$], res_o[$], res_w4[$], res_o4[$];
   int exp_w[$], exp_o[$], exp_w4[$], exp_o4[$];
   int drop_cnt = 0;
   int valid_cycles = 0;

   typedef struct {
      bit pol;
      int len;
      int exp_w;
      bit exp_o;
      int exp_w4;
      bit exp_o4;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   pulse_width_meter #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .pol(pol), .pulse_in(pulse_in),
      .width_out(width_out), .width_ovf(width_ovf), .width_valid(width_valid),
      .width_ready(width_ready), .busy(busy), .dropped(dropped)
   );

   pulse_width_meter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .pol(pol), .pulse_in(pulse_in),
      .width_out(w4_out), .width_ovf(w4_ovf), .width_valid(w4_valid),
      .width_ready(width_ready), .busy(w4_busy), .dropped(w4_dropped)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Inputs are set by callers right after a posedge; outputs are observed at negedge.
   task automatic step();
      @(negedge clk);
      if (width_valid) valid_cycles++;
      if (width_valid && width_ready) begin
         res_w.push_back(int'(width_out));
         res_o.push_back(int'(width_ovf));
      end
      if (w4_valid && width_ready) begin
         res_w4.push_back(int'(w4_out));
         res_o4.push_back(int'(w4_ovf));
      end
      if (dropped) drop_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic pulse(input bit act, input int n);
      pulse_in = act;
      repeat (n) step();
      pulse_in = ~act;
   endtask

   task automatic clear_q();
      res_w.delete(); res_o.delete(); res_w4.delete(); res_o4.delete();
      drop_cnt = 0;
      valid_cycles = 0;
   endtask

   task automatic rearm(input bit p);
      en = 1'b0;
      width_ready = 1'b1;
      pol = p;
      pulse_in = ~p;
      idle(5);
      en = 1'b1;
      idle(5);
   endtask

   initial begin
      bit cur_pol;
      int len, gap, held;

      rst = 1'b1; en = 1'b0; pol = 1'b1; pulse_in = 1'b0; width_ready = 1'b1;
      #1;
      chk("reset width_out", int'(width_out), 0);
      chk("reset valid", int'(width_valid), 0);
      chk("reset busy/ovf/dropped", int'({busy, width_ovf, dropped}), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      vecs[0] = '{1'b1, 5,  5,  1'b0, 5,  1'b0};
      vecs[1] = '{1'b0, 12, 12, 1'b0, 12, 1'b0};
      vecs[2] = '{1'b1, 20, 20, 1'b0, 15, 1'b1};
      vecs[3] = '{1'b1, 14, 14, 1'b0, 14, 1'b0};
      vecs[4] = '{1'b1, 15, 15, 1'b0, 15, 1'b1};
      vecs[5] = '{1'b0, 3,  3,  1'b0, 3,  1'b0};
      vecs[6] = '{1'b0, 16, 16, 1'b0, 15, 1'b1};

      for (int i = 0; i < 7; i++) begin
         rearm(vecs[i].pol);
         clear_q();
         pulse(vecs[i].pol, vecs[i].len);
         idle(12);
         chk($sformatf("vec%0d result count", i), res_w.size(), 1);
         chk($sformatf("vec%0d dut4 result count", i), res_w4.size(), 1);
         if (res_w.size() == 1) begin
            chk($sformatf("vec%0d width", i), res_w[0], vecs[i].exp_w);
            chk($sformatf("vec%0d ovf", i), res_o[0], int'(vecs[i].exp_o));
         end
         if (res_w4.size() == 1) begin
            chk($sformatf("vec%0d width4", i), res_w4[0], vecs[i].exp_w4);
            chk($sformatf("vec%0d ovf4", i), res_o4[0], int'(vecs[i].exp_o4));
         end
         if (i == 0) chk("vec0 valid cycles", valid_cycles, 1);
      end

      // Output register full: second result is dropped, first one held.
      rearm(1'b1);
      clear_q();
      width_ready = 1'b0;
      pulse(1'b1, 3);
      idle(8);
      pulse(1'b1, 7);
      idle(10);
      chk("full valid held", int'(width_valid), 1);
      chk("full width held", int'(width_out), 3);
      chk("full dropped strobes", drop_cnt, 1);
      width_ready = 1'b1;
      step();
      chk("full accept clears valid", int'(width_valid), 0);
      chk("full accepted count", res_w.size(), 1);
      if (res_w.size() == 1) chk("full accepted width", res_w[0], 3);

      // Line already active when enabled: that pulse must not be measured.
      en = 1'b0; pol = 1'b1; pulse_in = 1'b1;
      idle(5);
      clear_q();
      en = 1'b1;
      idle(6);
      pulse_in = 1'b0;
      idle(5);
      pulse(1'b1, 4);
      idle(12);
      chk("en-rise result count", res_w.size(), 1);
      if (res_w.size() == 1) chk("en-rise width", res_w[0], 4);

      // Disable mid-pulse: no result.
      clear_q();
      pulse_in = 1'b1;
      idle(6);
      chk("mid-pulse busy", int'(busy), 1);
      en = 1'b0;
      idle(3);
      pulse_in = 1'b0;
      idle(8);
      chk("disable mid-pulse count", res_w.size(), 0);
      chk("disable clears busy", int'(busy), 0);

      // Asynchronous reset mid-pulse with a held result.
      rearm(1'b1);
      width_ready = 1'b0;
      pulse(1'b1, 4);
      idle(6);
      pulse_in = 1'b1;
      idle(5);
      chk("pre-reset valid", int'(width_valid), 1);
      chk("pre-reset busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("async reset valid", int'(width_valid), 0);
      chk("async reset busy", int'(busy), 0);
      chk("async reset width", int'(width_out), 0);
      pulse_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      width_ready = 1'b1;
      idle(6);
      clear_q();
      pulse(1'b1, 5);
      idle(12);
      chk("post-reset count", res_w.size(), 1);
      if (res_w.size() == 1) chk("post-reset width", res_w[0], 5);

`ifdef GLITCH_FILTER_EN
      clear_q();
      pulse(1'b1, 2);
      idle(12);
      chk("glitch 2-cycle ignored", res_w.size(), 0);
      pulse(1'b1, 8);
      idle(14);
      chk("filtered 8-cycle count", res_w.size(), 1);
      if (res_w.size() == 1) chk("filtered 8-cycle width", res_w[0], 8);
`else
      clear_q();
      pulse(1'b1, 1);
      idle(12);
      chk("1-cycle count", res_w.size(), 1);
      if (res_w.size() == 1) chk("1-cycle width", res_w[0], 1);
`endif

      // Random pulses with a randomly stalling consumer that never causes a drop.
      cur_pol = 1'b1;
      rearm(cur_pol);
      clear_q();
      exp_w.delete(); exp_o.delete(); exp_w4.delete(); exp_o4.delete();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            cur_pol = ~cur_pol;
            rearm(cur_pol);
         end
`ifdef GLITCH_FILTER_EN
         len = $urandom_range(3, 40);
`else
         len = $urandom_range(1, 40);
`endif
         exp_w.push_back(len);
         exp_o.push_back(0);
         exp_w4.push_back(len < 15 ? len : 15);
         exp_o4.push_back(len >= 15 ? 1 : 0);
         width_ready = 1'b1;
         pulse(cur_pol, len);
         gap = $urandom_range(14, 22);
         held = 0;
         for (int g = 0; g < gap; g++) begin
            held = width_valid ? held + 1 : 0;
            width_ready = (held >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
         end
         width_ready = 1'b1;
         idle(2);
      end
      chk("random result count", res_w.size(), exp_w.size());
      chk("random dut4 count", res_w4.size(), exp_w4.size());
      chk("random drops", drop_cnt, 0);
      for (int k = 0; k < exp_w.size() && k < res_w.size(); k++) begin
         chk($sformatf("rand%0d width", k), res_w[k], exp_w[k]);
         chk($sformatf("rand%0d ovf", k), res_o[k], exp_o[k]);
      end
      for (int k = 0; k < exp_w4.size() && k < res_w4.size(); k++) begin
         chk($sformatf("rand%0d width4", k), res_w4[k], exp_w4[k]);
         chk($sformatf("rand%0d ovf4", k), res_o4[k], exp_o4[k]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
